// File: rtl/scope_pkg.sv
// Shared definitions for the scope capture controller.
// Optional build macro: SCOPE_AUTO_TRIG_EN enables the auto-trigger timeout
// in scope_capture_ctrl.
package scope_pkg;

  // Default geometry: one sample per visible VGA column
  localparam int SAMPLE_W_DEF     = 8;
  localparam int DEPTH_DEF        = 640;
  localparam int ADDR_W_DEF       = 10;
  localparam int AUTO_TIMEOUT_DEF = 4096;

  // Capture sequencer states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } scope_state_e;

  // Encoding of the trig_rising input
  localparam logic TRIG_FALLING = 1'b0;
  localparam logic TRIG_RISING  = 1'b1;

endpackage

// File: rtl/scope_capture_ctrl_if.sv
// Signal bundle between the sample source / VGA timing side (master) and the
// capture controller (slave). Also carries the sample RAM write port and the
// sequencer state for observation.
//
// Handshake: sample_valid and vsync_pulse are one-cycle strobes with no
// back-pressure; the controller accepts a sample on every cycle sample_valid
// is high, and the buf_we write port is a one-cycle strobe per write issued
// the cycle after the sample that caused it.
interface scope_capture_ctrl_if #(
  parameter int SAMPLE_W = 8,
  parameter int ADDR_W   = 10
);

  logic                run;
  logic                sample_valid;
  logic [SAMPLE_W-1:0] sample_data;
  logic [SAMPLE_W-1:0] trig_level;
  logic                trig_rising;
  logic                vsync_pulse;
  logic                buf_we;
  logic [ADDR_W:0]     buf_waddr;
  logic [SAMPLE_W-1:0] buf_wdata;
  logic                disp_bank;
  logic                triggered;
  logic                frame_swap;
  logic [1:0]          state;

  modport master (
    output run, sample_valid, sample_data, trig_level, trig_rising, vsync_pulse,
    input  buf_we, buf_waddr, buf_wdata, disp_bank, triggered, frame_swap, state
  );

  modport slave (
    input  run, sample_valid, sample_data, trig_level, trig_rising, vsync_pulse,
    output buf_we, buf_waddr, buf_wdata, disp_bank, triggered, frame_swap, state
  );

endinterface

// File: rtl/scope_trig_detect.sv
// Threshold-crossing detector. Remembers the previous accepted sample and
// flags, combinationally, when the current sample crosses trig_level in the
// selected direction. The first sample after a clear only primes the history.
module scope_trig_detect
  import scope_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clear,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_data,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic                trig_rising,
  output logic                hit
);

  logic [SAMPLE_W-1:0] prev;
  logic                prev_valid;
  logic                rise_x;
  logic                fall_x;

  // Sample history: cleared whenever the sequencer is not armed
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev       <= '0;
      prev_valid <= 1'b0;
    end else if (clear) begin
      prev_valid <= 1'b0;
    end else if (sample_valid) begin
      prev       <= sample_data;
      prev_valid <= 1'b1;
    end
  end

  // Crossing test on the incoming sample against the stored one
  always_comb begin
    rise_x = (prev < trig_level) && (sample_data >= trig_level);
    fall_x = (prev >= trig_level) && (sample_data < trig_level);
    hit    = 1'b0;
    if (sample_valid && prev_valid) begin
      hit = (trig_rising == TRIG_RISING) ? rise_x : fall_x;
    end
  end

endmodule

// File: rtl/scope_capture_ctrl.sv
// Trace capture sequencer for the scope display. Arms on a threshold crossing,
// writes one DEPTH-sample trace into the back bank of a double-buffered RAM
// and swaps banks only on vsync once the trace is complete.
// Optional build macro: SCOPE_AUTO_TRIG_EN forces a trigger after
// AUTO_TIMEOUT samples in ARMED without a natural crossing.
module scope_capture_ctrl
  import scope_pkg::*;
#(
  parameter int SAMPLE_W     = SAMPLE_W_DEF,
  parameter int DEPTH        = DEPTH_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int AUTO_TIMEOUT = AUTO_TIMEOUT_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  scope_capture_ctrl_if.slave  bus
);

  localparam logic [1:0] S_IDLE    = ST_IDLE;
  localparam logic [1:0] S_ARMED   = ST_ARMED;
  localparam logic [1:0] S_CAPTURE = ST_CAPTURE;
  localparam logic [1:0] S_DONE    = ST_DONE;

  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(DEPTH - 1);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [ADDR_W-1:0] col;
  logic [ADDR_W-1:0] col_nxt;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_col;
  logic              swap;
  logic              wbank;
  logic              samp_armed;
  logic              cross_hit;
  logic              auto_hit;
  logic              trig_fire;

  // The renderer owns disp_bank; captures always go to the other bank
  assign wbank = ~bus.disp_bank;

  // A sample is offered to the trigger logic only while armed and still running
  assign samp_armed = bus.sample_valid && (state == S_ARMED) && bus.run;

  scope_trig_detect #(
    .SAMPLE_W (SAMPLE_W)
  ) u_trig (
    .clock        (clock),
    .reset        (reset),
    .clear        (state != S_ARMED),
    .sample_valid (samp_armed),
    .sample_data  (bus.sample_data),
    .trig_level   (bus.trig_level),
    .trig_rising  (bus.trig_rising),
    .hit          (cross_hit)
  );

`ifdef SCOPE_AUTO_TRIG_EN
  localparam int TO_W = $clog2(AUTO_TIMEOUT + 1);

  logic [TO_W-1:0] to_cnt;

  // Count armed samples; cleared whenever the sequencer is outside ARMED
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (state != S_ARMED) begin
      to_cnt <= '0;
    end else if (samp_armed) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  // The AUTO_TIMEOUT-th armed sample is taken as the trigger
  assign auto_hit = samp_armed && (to_cnt == TO_W'(AUTO_TIMEOUT - 1));
`else
  logic unused_auto_cfg;

  assign unused_auto_cfg = (AUTO_TIMEOUT != 0);
  assign auto_hit        = 1'b0;
`endif

  assign trig_fire = samp_armed && (cross_hit || auto_hit);

  // Next-state, column and write-request decode
  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    wr_en     = 1'b0;
    wr_col    = '0;
    swap      = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.run) begin
          state_nxt = S_ARMED;
        end
      end
      S_ARMED: begin
        if (!bus.run) begin
          state_nxt = S_IDLE;
        end else if (trig_fire) begin
          // Triggering sample lands in column 0
          wr_en  = 1'b1;
          wr_col = '0;
          if (DEPTH == 1) begin
            state_nxt = S_DONE;
            col_nxt   = '0;
          end else begin
            state_nxt = S_CAPTURE;
            col_nxt   = ADDR_W'(1);
          end
        end
      end
      S_CAPTURE: begin
        if (!bus.run) begin
          // Abort: the partial back bank is simply never shown
          state_nxt = S_IDLE;
          col_nxt   = '0;
        end else if (bus.sample_valid) begin
          wr_en  = 1'b1;
          wr_col = col;
          if (col == LAST_COL) begin
            state_nxt = S_DONE;
            col_nxt   = '0;
          end else begin
            col_nxt = col + ADDR_W'(1);
          end
        end
      end
      S_DONE: begin
        // Samples are ignored here; a completed trace is always shown
        if (bus.vsync_pulse) begin
          swap      = 1'b1;
          state_nxt = bus.run ? S_ARMED : S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        col_nxt   = '0;
      end
    endcase
  end

  // Sequencer state and column counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      col   <= '0;
    end else begin
      state <= state_nxt;
      col   <= col_nxt;
    end
  end

  // Registered RAM write port: one-cycle strobe, address and data held after
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.buf_we    <= 1'b0;
      bus.buf_waddr <= '0;
      bus.buf_wdata <= '0;
    end else begin
      bus.buf_we <= wr_en;
      if (wr_en) begin
        bus.buf_waddr <= {wbank, wr_col};
        bus.buf_wdata <= bus.sample_data;
      end
    end
  end

  // Display bank flips only at a frame boundary after a complete trace
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.disp_bank  <= 1'b0;
      bus.frame_swap <= 1'b0;
    end else begin
      bus.frame_swap <= swap;
      if (swap) begin
        bus.disp_bank <= ~bus.disp_bank;
      end
    end
  end

  assign bus.triggered = (state == S_CAPTURE) || (state == S_DONE);
  assign bus.state     = state;

endmodule

// File: tb/tb_scope_capture_ctrl.sv
// Directed testbench for scope_capture_ctrl with DEPTH=8, AUTO_TIMEOUT=4.
// Writes are collected at the falling edge into obs_q as {waddr, wdata}.
module tb_scope_capture_ctrl;

  localparam int SW = 8;
  localparam int AW = 3;
  localparam int W  = AW + 1 + SW;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic clock;
  logic reset;

  scope_capture_ctrl_if #(.SAMPLE_W(SW), .ADDR_W(AW)) bus ();

  scope_capture_ctrl #(
    .SAMPLE_W     (SW),
    .DEPTH        (8),
    .ADDR_W       (AW),
    .AUTO_TIMEOUT (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int swap_cnt = 0;
  logic [W-1:0] obs_q[$];
  logic [W-1:0] exp_q[$];

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Write / swap monitor, sampled away from the active edge
  always @(negedge clock) begin
    if (bus.buf_we === 1'b1) obs_q.push_back({bus.buf_waddr, bus.buf_wdata});
    if (bus.frame_swap === 1'b1) swap_cnt++;
  end

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_sample(input logic [SW-1:0] d);
    bus.sample_valid = 1'b1;
    bus.sample_data  = d;
    @(posedge clock);
    #1;
    bus.sample_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset            = 1'b1;
    bus.run          = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_data  = '0;
    bus.trig_level   = 8'h80;
    bus.trig_rising  = 1'b1;
    bus.vsync_pulse  = 1'b0;
    tick(2);
    reset = 1'b0;
    obs_q.delete();
    exp_q.delete();
    swap_cnt = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.buf_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", bus.buf_we); end
    checks++; if (bus.buf_waddr !== 4'h0) begin errors++; $display("FAIL reset_waddr got %h exp 0", bus.buf_waddr); end
    checks++; if (bus.buf_wdata !== 8'h00) begin errors++; $display("FAIL reset_wdata got %h exp 00", bus.buf_wdata); end
    checks++; if (bus.disp_bank !== 1'b0) begin errors++; $display("FAIL reset_disp_bank got %b exp 0", bus.disp_bank); end
    checks++; if (bus.triggered !== 1'b0) begin errors++; $display("FAIL reset_triggered got %b exp 0", bus.triggered); end
    checks++; if (bus.frame_swap !== 1'b0) begin errors++; $display("FAIL reset_frame_swap got %b exp 0", bus.frame_swap); end
    checks++; if (bus.state !== S_IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", bus.state, S_IDLE); end
  endtask

  task automatic test_rising();
    do_reset();
    bus.run = 1'b1;
    tick(1);
    checks++; if (bus.state !== S_ARMED) begin errors++; $display("FAIL rise_armed got %0d exp %0d", bus.state, S_ARMED); end
    send_sample(8'h10);
    send_sample(8'h70);
    send_sample(8'h90);
    for (int i = 1; i < 8; i++) send_sample(8'(8'h90 + i));
    tick(1);
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, 3'(i), 8'(8'h90 + i)});
    checks++; if (obs_q.size() != 8) begin errors++; $display("FAIL rise_write_count got %0d exp 8", obs_q.size()); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rise_write[%0d] got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (bus.state !== S_DONE) begin errors++; $display("FAIL rise_done got %0d exp %0d", bus.state, S_DONE); end
    checks++; if (bus.triggered !== 1'b1) begin errors++; $display("FAIL rise_triggered got %b exp 1", bus.triggered); end
    bus.vsync_pulse = 1'b1;
    tick(1);
    bus.vsync_pulse = 1'b0;
    checks++; if (bus.disp_bank !== 1'b1) begin errors++; $display("FAIL rise_swap_bank got %b exp 1", bus.disp_bank); end
    checks++; if (bus.frame_swap !== 1'b1) begin errors++; $display("FAIL rise_swap_pulse got %b exp 1", bus.frame_swap); end
    tick(1);
    checks++; if (bus.frame_swap !== 1'b0) begin errors++; $display("FAIL rise_swap_one_cycle got %b exp 0", bus.frame_swap); end
    checks++; if (bus.state !== S_ARMED) begin errors++; $display("FAIL rise_rearm got %0d exp %0d", bus.state, S_ARMED); end
  endtask

  task automatic test_falling();
    do_reset();
    bus.trig_level  = 8'h40;
    bus.trig_rising = 1'b0;
    bus.run         = 1'b1;
    tick(1);
    send_sample(8'h50);
    send_sample(8'h40);
    tick(1);
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL fall_no_trig_at_level got %0d exp 0", obs_q.size()); end
    send_sample(8'h3F);
    tick(1);
    checks++; if (obs_q[0] !== 12'h83F) begin errors++; $display("FAIL fall_first_write got %h exp 83f", obs_q[0]); end
    for (int i = 1; i < 8; i++) send_sample(8'(8'h30 + i));
    tick(1);
    checks++; if (obs_q.size() != 8) begin errors++; $display("FAIL fall_write_count got %0d exp 8", obs_q.size()); end
    checks++; if (obs_q[7] !== 12'hF37) begin errors++; $display("FAIL fall_last_write got %h exp f37", obs_q[7]); end
  endtask

  task automatic test_abort();
    do_reset();
    bus.run = 1'b1;
    tick(1);
    send_sample(8'h10);
    send_sample(8'h90);
    send_sample(8'h91);
    send_sample(8'h92);
    bus.run = 1'b0;
    send_sample(8'h93);
    tick(2);
    checks++; if (bus.state !== S_IDLE) begin errors++; $display("FAIL abort_idle got %0d exp %0d", bus.state, S_IDLE); end
    checks++; if (obs_q.size() != 3) begin errors++; $display("FAIL abort_write_count got %0d exp 3", obs_q.size()); end
    for (int i = 0; i < 4; i++) send_sample(8'(8'h94 + i));
    bus.vsync_pulse = 1'b1;
    tick(1);
    bus.vsync_pulse = 1'b0;
    tick(3);
    bus.vsync_pulse = 1'b1;
    tick(1);
    bus.vsync_pulse = 1'b0;
    tick(2);
    checks++; if (obs_q.size() != 3) begin errors++; $display("FAIL abort_no_more_writes got %0d exp 3", obs_q.size()); end
    checks++; if (bus.disp_bank !== 1'b0) begin errors++; $display("FAIL abort_bank got %b exp 0", bus.disp_bank); end
    checks++; if (swap_cnt != 0) begin errors++; $display("FAIL abort_swaps got %0d exp 0", swap_cnt); end
  endtask

  task automatic test_vsync();
    do_reset();
    bus.run = 1'b1;
    tick(1);
    send_sample(8'h10);
    send_sample(8'h90);
    send_sample(8'h91);
    bus.vsync_pulse = 1'b1;
    send_sample(8'h92);
    bus.vsync_pulse = 1'b0;
    checks++; if (bus.disp_bank !== 1'b0) begin errors++; $display("FAIL vs_capture_bank got %b exp 0", bus.disp_bank); end
    checks++; if (bus.state !== S_CAPTURE) begin errors++; $display("FAIL vs_capture_state got %0d exp %0d", bus.state, S_CAPTURE); end
    for (int i = 3; i < 8; i++) send_sample(8'(8'h90 + i));
    tick(1);
    checks++; if (obs_q.size() != 8) begin errors++; $display("FAIL vs_write_count got %0d exp 8", obs_q.size()); end
    checks++; if (swap_cnt != 0) begin errors++; $display("FAIL vs_capture_swaps got %0d exp 0", swap_cnt); end
    bus.vsync_pulse = 1'b1;
    send_sample(8'h55);
    bus.vsync_pulse = 1'b0;
    checks++; if (bus.disp_bank !== 1'b1) begin errors++; $display("FAIL vs_done_bank got %b exp 1", bus.disp_bank); end
    checks++; if (bus.frame_swap !== 1'b1) begin errors++; $display("FAIL vs_done_swap got %b exp 1", bus.frame_swap); end
    tick(1);
    checks++; if (obs_q.size() != 8) begin errors++; $display("FAIL vs_dropped_sample got %0d exp 8", obs_q.size()); end
    obs_q.delete();
    send_sample(8'h10);
    send_sample(8'h90);
    tick(1);
    checks++; if (obs_q[0] !== 12'h090) begin errors++; $display("FAIL vs_next_bank0 got %h exp 090", obs_q[0]); end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.run = 1'b1;
    tick(1);
    send_sample(8'h10);
    send_sample(8'h90);
    send_sample(8'h91);
    #2;
    reset = 1'b1;
    #1;
    checks++; if (bus.buf_we !== 1'b0) begin errors++; $display("FAIL areset_we got %b exp 0", bus.buf_we); end
    checks++; if (bus.buf_waddr !== 4'h0) begin errors++; $display("FAIL areset_waddr got %h exp 0", bus.buf_waddr); end
    checks++; if (bus.buf_wdata !== 8'h00) begin errors++; $display("FAIL areset_wdata got %h exp 00", bus.buf_wdata); end
    checks++; if (bus.triggered !== 1'b0) begin errors++; $display("FAIL areset_triggered got %b exp 0", bus.triggered); end
    checks++; if (bus.state !== S_IDLE) begin errors++; $display("FAIL areset_state got %0d exp %0d", bus.state, S_IDLE); end
    tick(1);
    reset = 1'b0;
    tick(1);
    obs_q.delete();
    checks++; if (bus.state !== S_ARMED) begin errors++; $display("FAIL areset_armed got %0d exp %0d", bus.state, S_ARMED); end
    send_sample(8'h90);
    tick(1);
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL areset_first_primes got %0d exp 0", obs_q.size()); end
    send_sample(8'h10);
    send_sample(8'h90);
    tick(1);
    checks++; if (obs_q[0] !== 12'h890) begin errors++; $display("FAIL areset_retrigger got %h exp 890", obs_q[0]); end
  endtask

  task automatic test_auto_trig();
    do_reset();
    bus.run = 1'b1;
    tick(1);
`ifdef SCOPE_AUTO_TRIG_EN
    for (int i = 0; i < 3; i++) send_sample(8'h20);
    tick(1);
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL auto_early got %0d exp 0", obs_q.size()); end
    send_sample(8'h20);
    tick(1);
    checks++; if (obs_q[0] !== 12'h820) begin errors++; $display("FAIL auto_forced got %h exp 820", obs_q[0]); end
    checks++; if (bus.state !== S_CAPTURE) begin errors++; $display("FAIL auto_capture got %0d exp %0d", bus.state, S_CAPTURE); end
`else
    for (int i = 0; i < 100; i++) send_sample(8'h20);
    tick(1);
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL noauto_writes got %0d exp 0", obs_q.size()); end
    checks++; if (bus.state !== S_ARMED) begin errors++; $display("FAIL noauto_armed got %0d exp %0d", bus.state, S_ARMED); end
`endif
  endtask

  // Sequence of scenarios and final report
  initial begin
    reset            = 1'b1;
    bus.run          = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_data  = '0;
    bus.trig_level   = '0;
    bus.trig_rising  = 1'b1;
    bus.vsync_pulse  = 1'b0;
    test_reset();
    test_rising();
    test_falling();
    test_abort();
    test_vsync();
    test_async_reset();
    test_auto_trig();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scope_capture_ctrl.md
Name: scope_capture_ctrl

Overview:
Sequences trace capture for the scope display. Arms on a trigger condition in the incoming sample stream and writes one frame-width trace into the back bank of a double-buffered sample RAM. Swaps banks only at a frame boundary (vsync), so the VGA renderer never sees a partially written trace. Sits between the sample source and the sample RAM; the renderer reads from the bank indicated by disp_bank.

Parameters:
SAMPLE_W, 8, sample and trigger-level width (unsigned)
DEPTH, 640, samples per trace, one per visible column
ADDR_W, 10, address width per bank; must satisfy 2**ADDR_W >= DEPTH
AUTO_TIMEOUT, 4096, samples in ARMED before a forced trigger (only with SCOPE_AUTO_TRIG_EN)

Ports:
clock  in  1  system clock; all logic on the rising edge
reset  in  1  asynchronous, active-high reset
run  in  1  level; 1 = acquire continuously, 0 = stop/idle
sample_valid  in  1  one-cycle strobe qualifying sample_data
sample_data  in  SAMPLE_W  unsigned sample
trig_level  in  SAMPLE_W  trigger threshold
trig_rising  in  1  1 = rising-edge trigger, 0 = falling-edge trigger
vsync_pulse  in  1  one-cycle frame-start strobe from the VGA timing block
buf_we  out  1  sample RAM write enable
buf_waddr  out  ADDR_W+1  MSB = bank, LSBs = column index
buf_wdata  out  SAMPLE_W  write data
disp_bank  out  1  bank the renderer must read
triggered  out  1  high in CAPTURE and DONE
frame_swap  out  1  one-cycle pulse on the cycle disp_bank toggles

Behaviour:
- Reset (asynchronous): state=IDLE; buf_we=0, buf_waddr=0, buf_wdata=0, disp_bank=0, triggered=0, frame_swap=0; prev_valid=0; column counter=0.
- Write bank is always ~disp_bank.
- States:
  IDLE: run=1 -> ARMED (prev_valid cleared).
  ARMED: on each sample_valid, store sample as prev and set prev_valid. Trigger when prev_valid and (rising: prev < trig_level and cur >= trig_level; falling: prev >= trig_level and cur < trig_level). On trigger, write the triggering sample to column 0 and go to CAPTURE with counter=1.
  CAPTURE: each sample_valid writes to column counter, then the counter increments. When the write to column DEPTH-1 is issued -> DONE.
  DONE: ignore samples. On vsync_pulse: toggle disp_bank, pulse frame_swap, then go to ARMED if run=1, else IDLE.
- Write latency: buf_we/buf_waddr/buf_wdata are registered and are valid the cycle after the qualifying sample_valid. buf_we is high for exactly one cycle per write.
- Abort: run=0 in ARMED or CAPTURE -> IDLE next cycle. No swap occurs, and the partially written back bank is discarded. A write already registered completes; no further writes are issued.
- run=0 in DONE: remain in DONE until vsync, swap, then go to IDLE. A completed trace is always shown.
- vsync_pulse outside DONE has no effect.
- sample_valid coincident with vsync_pulse in DONE: sample dropped, swap proceeds.
- Back-to-back sample_valid on every cycle must be sustained with no drops in CAPTURE.
- Column counter never exceeds DEPTH-1; the address LSBs never wrap within a capture.

Optional Feature:
SCOPE_AUTO_TRIG_EN
- Defined: a timeout counter counts sample_valid strobes in ARMED. When it reaches AUTO_TIMEOUT with no trigger, the current sample is treated as the trigger. The counter clears on entering ARMED.
- Undefined: no timeout logic. ARMED waits indefinitely.

Decomposition:
- Package scope_pkg: state enum typedef (IDLE, ARMED, CAPTURE, DONE), default SAMPLE_W/DEPTH/ADDR_W constants, and the trigger-polarity encoding.
- Sub-module scope_trig_detect: holds prev/prev_valid and computes the rising/falling threshold-crossing flag combinationally from the current sample. It is instantiated once.

Test Plan:
1. DEPTH=8, trig_level=0x80, trig_rising=1, run=1, samples 0x10,0x70,0x90,0x91..0x97 -> first write is 0x90 to addr {1,0}, then 7 consecutive writes to {1,1..7}; DONE; next vsync -> disp_bank=1, frame_swap one cycle.
2. Falling trigger, level 0x40, samples 0x50,0x40,0x3F -> no trigger on 0x40 (0x50->0x40 is not falling below the level), trigger on 0x3F; capture writes to bank 1.
3. run dropped after 3 captured samples (DEPTH=8) -> IDLE, no further buf_we, disp_bank stays 0 through subsequent vsyncs.
4. vsync_pulse during CAPTURE ignored; vsync coincident with sample_valid in DONE -> swap occurs, no write that cycle; next capture targets the new back bank (bank 0).
5. reset asserted mid-CAPTURE, asynchronously between clock edges -> all outputs 0 immediately; after release with run=1, ARMED, and the first sample only sets prev (never triggers).
6. With SCOPE_AUTO_TRIG_EN and AUTO_TIMEOUT=4, constant samples 0x20, level 0x80 -> forced trigger on 4th sample, 0x20 written to column 0; without macro -> no writes after 100 samples.
